booth_job_sequencer: RTL and testbench

- Upstream/downstream wrapper for the radix-2 Booth multiplier datapath and its controller.
- Accepts operand pairs over a valid/ready stream and buffers them in a 2-entry FIFO.
- Drives the multiplier's clear, start and shared data bus in the exact per-cycle order the controller expects.
- Waits for done, captures the 2W-bit product {A,Q} into a held output register and presents it over valid/ready, with a job tag.

---
 rtl/booth_pkg.sv | 10 +
 rtl/booth_job_fifo.sv | 33 +++
 rtl/booth_job_sequencer.sv | 123 ++++++++++++
 tb/tb_booth_job_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// booth_pkg: shared states, default widths and job record for the Booth job sequencer
package booth_pkg;
    localparam int BOOTH_W = 16;
    localparam int BOOTH_TAG_W = 4;
    typedef enum logic [2:0] {IDLE, CLR, START, LDM, LDQ, RUN} booth_seq_state_t;
    typedef struct packed {
        logic [BOOTH_W-1:0] mcand;
        logic [BOOTH_W-1:0] mplier;
    } booth_job_t;
endpackage

// File: rtl/booth_job_fifo.sv
// booth_job_fifo: 2-entry job FIFO (clk, rst, push/wdata in, pop in, head/full/empty out)
import booth_pkg::*;
module booth_job_fifo #(
    parameter type T = booth_job_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  T     wdata,
    output T     head,
    output logic full,
    output logic empty
);
    T mem [2];
    logic wp, rp;
    logic [1:0] cnt;
    always_ff @(posedge clk)
        if (push) mem[wp] <= wdata;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp <= 1'b0;
            rp <= 1'b0;
            cnt <= 2'd0;
        end else begin
            wp <= push ? ~wp : wp;
            rp <= pop ? ~rp : rp;
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    assign head = mem[rp];
    assign full = cnt == 2'd2;
    assign empty = cnt == 2'd0;
endmodule

// File: rtl/booth_job_sequencer.sv
// booth_job_sequencer: operand stream -> Booth multiplier clr/start/load sequencing -> tagged product stream (BOOTH_SEQ_TIMEOUT_EN adds a RUN timeout with res_err)
import booth_pkg::*;
module booth_job_sequencer #(
    parameter int W = BOOTH_W,
    parameter int TAG_W = BOOTH_TAG_W,
    parameter int TIMEOUT = 2*W+8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_mcand,
    input  logic [W-1:0]     in_mplier,
    output logic             mul_clr,
    output logic             mul_start,
    output logic [W-1:0]     mul_data,
    input  logic             mul_done,
    input  logic [W-1:0]     mul_a,
    input  logic [W-1:0]     mul_q,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [2*W-1:0]   res_product,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err
);
    typedef struct packed {
        logic [W-1:0] mcand;
        logic [W-1:0] mplier;
    } job_t;
    booth_seq_state_t state, state_nx;
    job_t in_job, head;
    logic full, empty, push, pop, done_ok, to_hit, timeout_cond;
    logic [TAG_W-1:0] tag;
    assign in_job = {in_mcand, in_mplier};
    assign push = in_valid && in_ready;
    assign in_ready = !full && !rst;
    booth_job_fifo #(.T(job_t)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .wdata(in_job),
        .head(head),
        .full(full),
        .empty(empty)
    );
    always_comb begin
        state_nx = state;
        mul_clr = 1'b0;
        mul_start = 1'b0;
        mul_data = '0;
        pop = 1'b0;
        done_ok = 1'b0;
        to_hit = 1'b0;
        case (state)
            IDLE: state_nx = (!empty && !res_valid) ? CLR : IDLE;
            CLR: begin
                mul_clr = 1'b1;
                state_nx = START;
            end
            START: begin
                mul_start = 1'b1;
                mul_data = head.mcand;
                state_nx = LDM;
            end
            LDM: begin
                mul_data = head.mcand;
                state_nx = LDQ;
            end
            LDQ: begin
                mul_data = head.mplier;
                pop = 1'b1;
                state_nx = RUN;
            end
            RUN: begin
                done_ok = mul_done;
                to_hit = timeout_cond && !mul_done;
                mul_clr = to_hit;
                state_nx = (done_ok || to_hit) ? IDLE : RUN;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            tag <= '0;
            res_valid <= 1'b0;
            res_product <= '0;
            res_tag <= '0;
        end else begin
            state <= state_nx;
            if (done_ok || to_hit) begin
                res_valid <= 1'b1;
                res_product <= done_ok ? {mul_a, mul_q} : '0;
                res_tag <= tag;
                tag <= tag + 1'b1;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
`ifdef BOOTH_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT+1);
    logic [CW-1:0] run_cnt;
    logic err_q;
    // counter holds 0 outside RUN, so the last RUN cycle before it would reach TIMEOUT is the timeout cycle
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            run_cnt <= '0;
            err_q <= 1'b0;
        end else begin
            run_cnt <= (state == RUN) ? run_cnt + 1'b1 : '0;
            err_q <= (done_ok || to_hit) ? to_hit : err_q;
        end
    assign timeout_cond = run_cnt == CW'(TIMEOUT-1);
    assign res_err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_cond = 1'b0;
    assign res_err = 1'b0;
`endif
endmodule

// File: tb/tb_booth_job_sequencer.sv
// tb_booth_job_sequencer: scoreboard bench with a behavioural multiplier stand-in
module tb_booth_job_sequencer;
    localparam int W = 16;
    localparam int TAG_W = 4;
    localparam int DLY = 17;
    typedef struct {
        logic [W-1:0] mc;
        logic [W-1:0] mp;
        logic [2*W-1:0] prod;
    } vec_t;
    typedef struct {
        logic [2*W-1:0] prod;
        logic [TAG_W-1:0] tag;
        logic err;
    } exp_t;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, res_ready = 1'b0, spur_done = 1'b0, m_done, m_never = 1'b0;
    logic [W-1:0] in_mcand = '0, in_mplier = '0, mul_data, mul_a, mul_q, m_mc;
    logic in_ready, mul_clr, mul_start, mul_done, res_valid, res_err;
    logic [2*W-1:0] res_product, m_p;
    logic [TAG_W-1:0] res_tag, exp_tag = '0;
    logic [1:0] ph;
    int m_cnt, n_chk = 0, n_fail = 0, last_tag = -1;
    bit seen_wrap = 0;
    exp_t sb[$];
    vec_t vt[8];
    assign mul_done = m_done | spur_done;
    always #5 clk = ~clk;
    booth_job_sequencer #(.W(W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mcand(in_mcand), .in_mplier(in_mplier), .mul_clr(mul_clr),
        .mul_start(mul_start), .mul_data(mul_data), .mul_done(mul_done),
        .mul_a(mul_a), .mul_q(mul_q), .res_valid(res_valid), .res_ready(res_ready),
        .res_product(res_product), .res_tag(res_tag), .res_err(res_err)
    );
    function automatic logic [2*W-1:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] r;
        r = $signed(a) * $signed(b);
        return r;
    endfunction
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    // multiplier stand-in: latches M and Q in the load cycles, answers DLY RUN cycles later
    always @(posedge clk or posedge rst)
        if (rst) begin
            ph <= 2'd0;
            m_done <= 1'b0;
            mul_a <= '0;
            mul_q <= '0;
            m_cnt <= 0;
        end else begin
            m_done <= 1'b0;
            case (ph)
                2'd0: if (mul_start) ph <= 2'd1;
                2'd1: begin
                    m_mc <= mul_data;
                    ph <= 2'd2;
                end
                2'd2: begin
                    m_p <= smul(m_mc, mul_data);
                    m_cnt <= 0;
                    ph <= 2'd3;
                end
                default: if (m_cnt == DLY && !m_never) begin
                    m_done <= 1'b1;
                    {mul_a, mul_q} <= m_p;
                    ph <= 2'd0;
                end else m_cnt <= m_cnt + 1;
            endcase
            if (mul_clr) ph <= 2'd0;
        end
    always @(negedge clk)
        if (!rst && res_valid && res_ready) begin
            exp_t e;
            chk("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("product", res_product, e.prod);
                chk("tag", res_tag, e.tag);
                chk("err", res_err, e.err);
            end
            if (last_tag == 15 && res_tag == 0) seen_wrap = 1;
            last_tag = res_tag;
        end
    task automatic push(input logic [W-1:0] mc, input logic [W-1:0] mp, input logic [2*W-1:0] p, input logic e);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", in_ready, 1);
        if (!in_ready) return;
        in_valid = 1'b1;
        in_mcand = mc;
        in_mplier = mp;
        @(posedge clk);
        sb.push_back('{p, exp_tag, e});
        exp_tag++;
        #1 in_valid = 1'b0;
    endtask
    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask
    task automatic wait_start();
        int n = 0;
        while (!mul_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", mul_start, 1);
    endtask
    task automatic chk_zero(input string nm);
        chk({nm, "_clr"}, mul_clr, 0);
        chk({nm, "_start"}, mul_start, 0);
        chk({nm, "_data"}, mul_data, 0);
        chk({nm, "_in_ready"}, in_ready, 0);
        chk({nm, "_valid"}, res_valid, 0);
        chk({nm, "_prod"}, res_product, 0);
        chk({nm, "_tag"}, res_tag, 0);
        chk({nm, "_err"}, res_err, 0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        vt[0] = '{16'd3, 16'hFFFB, 32'hFFFF_FFF1};
        vt[1] = '{16'd0, 16'd7, 32'h0};
        vt[2] = '{16'hFFFF, 16'hFFFF, 32'h1};
        vt[3] = '{16'h7FFF, 16'h7FFF, 32'h3FFF_0001};
        vt[4] = '{16'h8000, 16'h8000, 32'h4000_0000};
        vt[5] = '{16'h8000, 16'h7FFF, 32'hC000_8000};
        vt[6] = '{16'd100, 16'd200, 32'h4E20};
        vt[7] = '{16'hFFFE, 16'd3, 32'hFFFF_FFFA};
        #3 chk_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        res_ready = 1'b1;
        @(negedge clk) chk("in_ready_after_reset", in_ready, 1);
        push(16'd3, 16'hFFFB, 32'hFFFF_FFF1, 1'b0);
        @(negedge clk) chk("t1_idle_clr", mul_clr, 0);
        @(negedge clk) chk("t1_clr", mul_clr, 1);
        @(negedge clk) begin
            chk("t1_start", mul_start, 1);
            chk("t1_data_start", mul_data, 16'd3);
        end
        @(negedge clk) begin
            chk("t1_ldm_start", mul_start, 0);
            chk("t1_data_ldm", mul_data, 16'd3);
        end
        @(negedge clk) chk("t1_data_ldq", mul_data, 16'hFFFB);
        @(negedge clk) chk("t1_data_run", mul_data, 16'h0);
        drain();
        push(vt[0].mc, vt[0].mp, vt[0].prod, 1'b0);
        push(vt[1].mc, vt[1].mp, vt[1].prod, 1'b0);
        @(negedge clk) chk("in_ready_full", in_ready, 0);
        for (int i = 2; i < 8; i++) push(vt[i].mc, vt[i].mp, vt[i].prod, 1'b0);
        drain();
        @(posedge clk) #1 res_ready = 1'b0;
        push(vt[3].mc, vt[3].mp, vt[3].prod, 1'b0);
        push(vt[4].mc, vt[4].mp, vt[4].prod, 1'b0);
        for (int n = 0; n < 200 && !res_valid; n++) @(negedge clk);
        chk("stall_valid", res_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_hold_valid", res_valid, 1);
            chk("stall_hold_prod", res_product, vt[3].prod);
            chk("stall_hold_tag", res_tag, sb[0].tag);
            chk("stall_no_clr", mul_clr, 0);
            chk("stall_no_start", mul_start, 0);
        end
        @(posedge clk) #1 res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk) begin
            chk("post_hs_valid", res_valid, 0);
            chk("post_hs_idle", mul_clr, 0);
        end
        @(negedge clk) chk("post_hs_clr", mul_clr, 1);
        drain();
        push(vt[5].mc, vt[5].mp, vt[5].prod, 1'b0);
        push(vt[6].mc, vt[6].mp, vt[6].prod, 1'b0);
        wait_start();
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_zero("midrun_reset");
        sb.delete();
        exp_tag = '0;
        last_tag = -1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk) chk("rst_fifo_empty", in_ready, 1);
        @(posedge clk) #1 spur_done = 1'b1;
        @(posedge clk) #1 spur_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_result_after_reset", res_valid, 0);
            chk("flushed_no_clr", mul_clr, 0);
        end
        push(vt[6].mc, vt[6].mp, vt[6].prod, 1'b0);
        drain();
`ifdef BOOTH_SEQ_TIMEOUT_EN
        begin
            int k = 0, clr_k = -1, val_k = -1;
            m_never = 1'b1;
            push(16'd9, 16'd9, '0, 1'b1);
            wait_start();
            while (val_k < 0 && k < 100) begin
                @(negedge clk);
                k++;
                if (mul_clr && clr_k < 0) clr_k = k;
                if (res_valid && val_k < 0) val_k = k;
            end
            chk("timeout_clr_cycle", clr_k, 42);
            chk("timeout_valid_cycle", val_k, 43);
            m_never = 1'b0;
            push(vt[7].mc, vt[7].mp, vt[7].prod, 1'b0);
            drain();
        end
`endif
        for (int i = 0; i < 16; i++) push(vt[i%8].mc, vt[i%8].mp, vt[i%8].prod, 1'b0);
        drain();
        chk("tag_wrap", seen_wrap, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
